mcu_subsys_sram_arbiter: RTL and testbench

Two-master, one-slave arbiter that shares the MCU SRAM between the CPU path (fed by the host bridge SRAM port) and the GNSS sample DMA master.
- Transaction-granular round-robin with a registered grant.
- Grant is held until the SRAM completes the transaction.
- Watchdog timeout terminates any transaction whose slave never responds.
- Sits between the host bridge / DMA engine and the SRAM controller.

---
 rtl/mcu_subsys_sram_arbiter.sv | 159 +++++++++++++++
 tb/tb_mcu_subsys_sram_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_subsys_sram_arbiter.sv
// Two-master (CPU, GNSS DMA) to one-slave SRAM arbiter.
// Round-robin at transaction granularity, grant held until the SRAM
// completes. A watchdog terminates transactions the SRAM never answers.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no grant; arbitrate between pending requests
//   GNT_CPU | CPU owns the SRAM port until completion, abort or timeout
//   GNT_DMA | DMA owns the SRAM port until completion, abort or timeout
module mcu_subsys_sram_arbiter #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 64,
  parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic                sys_clk,
  input  logic                rst_n,

  input  logic                cpu_mem_valid,
  output logic                cpu_mem_ready,
  input  logic [ADDR_W-1:0]   cpu_mem_addr,
  input  logic [DATA_W-1:0]   cpu_mem_wdata,
  input  logic [DATA_W/8-1:0] cpu_mem_wstrb,
  output logic [DATA_W-1:0]   cpu_mem_rdata,

  input  logic                dma_mem_valid,
  output logic                dma_mem_ready,
  input  logic [ADDR_W-1:0]   dma_mem_addr,
  input  logic [DATA_W-1:0]   dma_mem_wdata,
  input  logic [DATA_W/8-1:0] dma_mem_wstrb,
  output logic [DATA_W-1:0]   dma_mem_rdata,

  output logic                sram_mem_valid,
  input  logic                sram_mem_ready,
  output logic [ADDR_W-1:0]   sram_mem_addr,
  output logic [DATA_W-1:0]   sram_mem_wdata,
  output logic [DATA_W/8-1:0] sram_mem_wstrb,
  input  logic [DATA_W-1:0]   sram_mem_rdata,

  output logic                timeout_err,
  output logic [1:0]          grant_owner
);

  // Watchdog is a down-counter loaded on grant entry; terminal count 0
  // marks the TIMEOUT_CYCLES-th cycle spent in the grant state.
  localparam bit              WD_ON     = (TIMEOUT_CYCLES != 0);
  localparam int              WD_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int              WD_LOAD_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [WD_W-1:0] WD_LOAD   = WD_LOAD_I[WD_W-1:0];

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GNT_CPU = 2'b01,
    GNT_DMA = 2'b10
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            last_dma;
  logic            last_dma_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic [WD_W-1:0] wd_cnt_nxt;
  logic            wd_tc;

  assign wd_tc = WD_ON && (wd_cnt == '0);

  // State, round-robin pointer, watchdog and registered grant status.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_dma    <= 1'b1;
      wd_cnt      <= '0;
      grant_owner <= 2'b00;
    end else begin
      state       <= state_nxt;
      last_dma    <= last_dma_nxt;
      wd_cnt      <= wd_cnt_nxt;
      grant_owner <= 2'(state_nxt);
    end
  end

  // Arbitration, request muxing, completion forwarding and watchdog expiry.
  always_comb begin
    state_nxt      = state;
    last_dma_nxt   = last_dma;
    wd_cnt_nxt     = wd_cnt;
    sram_mem_valid = 1'b0;
    sram_mem_addr  = cpu_mem_addr;
    sram_mem_wdata = cpu_mem_wdata;
    sram_mem_wstrb = cpu_mem_wstrb;
    cpu_mem_ready  = 1'b0;
    cpu_mem_rdata  = '0;
    dma_mem_ready  = 1'b0;
    dma_mem_rdata  = '0;
    timeout_err    = 1'b0;

    case (state)
      IDLE: begin
        wd_cnt_nxt = WD_LOAD;
        if (cpu_mem_valid && dma_mem_valid) begin
          state_nxt = last_dma ? GNT_CPU : GNT_DMA;
        end else if (cpu_mem_valid) begin
          state_nxt = GNT_CPU;
        end else if (dma_mem_valid) begin
          state_nxt = GNT_DMA;
        end
      end

      GNT_CPU: begin
        sram_mem_valid = cpu_mem_valid;
        cpu_mem_rdata  = sram_mem_rdata;
        if (wd_cnt != '0) wd_cnt_nxt = wd_cnt - WD_W'(1);
        if (sram_mem_ready) begin
          cpu_mem_ready = 1'b1;
          state_nxt     = IDLE;
          last_dma_nxt  = 1'b0;
        end else if (!cpu_mem_valid) begin
          // abort: master withdrew, pointer left untouched
          state_nxt = IDLE;
        end else if (wd_tc) begin
          sram_mem_valid = 1'b0;
          cpu_mem_ready  = 1'b1;
          cpu_mem_rdata  = TIMEOUT_RDATA;
          timeout_err    = 1'b1;
          state_nxt      = IDLE;
          last_dma_nxt   = 1'b0;
        end
      end

      GNT_DMA: begin
        sram_mem_valid = dma_mem_valid;
        sram_mem_addr  = dma_mem_addr;
        sram_mem_wdata = dma_mem_wdata;
        sram_mem_wstrb = dma_mem_wstrb;
        dma_mem_rdata  = sram_mem_rdata;
        if (wd_cnt != '0) wd_cnt_nxt = wd_cnt - WD_W'(1);
        if (sram_mem_ready) begin
          dma_mem_ready = 1'b1;
          state_nxt     = IDLE;
          last_dma_nxt  = 1'b1;
        end else if (!dma_mem_valid) begin
          state_nxt = IDLE;
        end else if (wd_tc) begin
          sram_mem_valid = 1'b0;
          dma_mem_ready  = 1'b1;
          dma_mem_rdata  = TIMEOUT_RDATA;
          timeout_err    = 1'b1;
          state_nxt      = IDLE;
          last_dma_nxt   = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mcu_subsys_sram_arbiter.sv
// Directed bench for mcu_subsys_sram_arbiter: a per-cycle vector table for
// arbitration/masking/abort, plus hand sequences for watchdog and reset.
module tb_mcu_subsys_sram_arbiter;

  localparam logic [31:0] CPU_ADDR  = 32'h4000_0010;
  localparam logic [31:0] CPU_WDATA = 32'h5A5A_0000;
  localparam logic [3:0]  CPU_WSTRB = 4'b0000;
  localparam logic [31:0] DMA_ADDR  = 32'h4000_0100;
  localparam logic [31:0] DMA_WDATA = 32'hA5A5_A5A5;
  localparam logic [3:0]  DMA_WSTRB = 4'b0011;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        cpu_mem_valid, cpu_mem_ready;
  logic [31:0] cpu_mem_addr, cpu_mem_wdata, cpu_mem_rdata;
  logic [3:0]  cpu_mem_wstrb;
  logic        dma_mem_valid, dma_mem_ready;
  logic [31:0] dma_mem_addr, dma_mem_wdata, dma_mem_rdata;
  logic [3:0]  dma_mem_wstrb;
  logic        sram_mem_valid, sram_mem_ready;
  logic [31:0] sram_mem_addr, sram_mem_wdata, sram_mem_rdata;
  logic [3:0]  sram_mem_wstrb;
  logic        timeout_err;
  logic [1:0]  grant_owner;

  int passed = 0;
  int total  = 0;

  always #5 sys_clk = ~sys_clk;

  mcu_subsys_sram_arbiter dut (
    .sys_clk        (sys_clk),
    .rst_n          (rst_n),
    .cpu_mem_valid  (cpu_mem_valid),
    .cpu_mem_ready  (cpu_mem_ready),
    .cpu_mem_addr   (cpu_mem_addr),
    .cpu_mem_wdata  (cpu_mem_wdata),
    .cpu_mem_wstrb  (cpu_mem_wstrb),
    .cpu_mem_rdata  (cpu_mem_rdata),
    .dma_mem_valid  (dma_mem_valid),
    .dma_mem_ready  (dma_mem_ready),
    .dma_mem_addr   (dma_mem_addr),
    .dma_mem_wdata  (dma_mem_wdata),
    .dma_mem_wstrb  (dma_mem_wstrb),
    .dma_mem_rdata  (dma_mem_rdata),
    .sram_mem_valid (sram_mem_valid),
    .sram_mem_ready (sram_mem_ready),
    .sram_mem_addr  (sram_mem_addr),
    .sram_mem_wdata (sram_mem_wdata),
    .sram_mem_wstrb (sram_mem_wstrb),
    .sram_mem_rdata (sram_mem_rdata),
    .timeout_err    (timeout_err),
    .grant_owner    (grant_owner)
  );

  typedef struct {
    logic        cpu_v;
    logic        dma_v;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_sv;
    logic        e_cr;
    logic        e_dr;
    logic [1:0]  e_own;
    logic        e_dsel;
    logic [31:0] e_crd;
    logic [31:0] e_drd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic add(input logic cv, input logic dv, input logic r, input logic [31:0] rd,
                     input logic sv, input logic cr, input logic dr, input logic [1:0] own,
                     input logic dsel, input logic [31:0] crd, input logic [31:0] drd);
    vec_t v;
    v = '{cv, dv, r, rd, sv, cr, dr, own, dsel, crd, drd};
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic early;
    rst_n          = 1'b0;
    cpu_mem_valid  = 1'b0;
    dma_mem_valid  = 1'b0;
    cpu_mem_addr   = CPU_ADDR;
    cpu_mem_wdata  = CPU_WDATA;
    cpu_mem_wstrb  = CPU_WSTRB;
    dma_mem_addr   = DMA_ADDR;
    dma_mem_wdata  = DMA_WDATA;
    dma_mem_wstrb  = DMA_WSTRB;
    sram_mem_ready = 1'b0;
    sram_mem_rdata = '0;

    //   cpu dma rdy rdata          sv cr dr own   dsel crd            drd
    add(1, 0, 0, 32'h0,           0, 0, 0, 2'b00, 0, 32'h0,         32'h0);
    add(1, 0, 0, 32'h0,           1, 0, 0, 2'b01, 0, 32'h0,         32'h0);
    add(1, 0, 1, 32'h1234_5678,   1, 1, 0, 2'b01, 0, 32'h1234_5678, 32'h0);
    add(0, 0, 0, 32'h0,           0, 0, 0, 2'b00, 0, 32'h0,         32'h0);
    add(0, 1, 0, 32'h0,           0, 0, 0, 2'b00, 0, 32'h0,         32'h0);
    add(0, 1, 0, 32'h0,           1, 0, 0, 2'b10, 1, 32'h0,         32'h0);
    add(0, 1, 1, 32'h1111_0000,   1, 0, 1, 2'b10, 1, 32'h0,         32'h1111_0000);
    add(0, 0, 0, 32'h0,           0, 0, 0, 2'b00, 0, 32'h0,         32'h0);
    add(1, 1, 0, 32'h0,           0, 0, 0, 2'b00, 0, 32'h0,         32'h0);
    add(1, 1, 0, 32'h0,           1, 0, 0, 2'b01, 0, 32'h0,         32'h0);
    add(1, 1, 1, 32'h0000_00C1,   1, 1, 0, 2'b01, 0, 32'h0000_00C1, 32'h0);
    add(1, 1, 0, 32'h0,           0, 0, 0, 2'b00, 0, 32'h0,         32'h0);
    add(1, 1, 0, 32'h0,           1, 0, 0, 2'b10, 1, 32'h0,         32'h0);
    add(1, 1, 1, 32'h0000_00D1,   1, 0, 1, 2'b10, 1, 32'h0,         32'h0000_00D1);
    add(1, 1, 0, 32'h0,           0, 0, 0, 2'b00, 0, 32'h0,         32'h0);
    add(1, 1, 0, 32'h0,           1, 0, 0, 2'b01, 0, 32'h0,         32'h0);
    add(1, 1, 1, 32'h0000_00C2,   1, 1, 0, 2'b01, 0, 32'h0000_00C2, 32'h0);
    add(1, 1, 0, 32'h0,           0, 0, 0, 2'b00, 0, 32'h0,         32'h0);
    add(1, 1, 0, 32'h0,           1, 0, 0, 2'b10, 1, 32'h0,         32'h0);
    add(1, 1, 1, 32'h0000_00D2,   1, 0, 1, 2'b10, 1, 32'h0,         32'h0000_00D2);
    add(0, 0, 0, 32'h0,           0, 0, 0, 2'b00, 0, 32'h0,         32'h0);
    add(0, 0, 1, 32'hFFFF_FFFF,   0, 0, 0, 2'b00, 0, 32'h0,         32'h0);
    add(1, 0, 0, 32'h0,           0, 0, 0, 2'b00, 0, 32'h0,         32'h0);
    add(1, 0, 0, 32'h0,           1, 0, 0, 2'b01, 0, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,           0, 0, 0, 2'b01, 0, 32'h0,         32'h0);
    add(1, 1, 0, 32'h0,           0, 0, 0, 2'b00, 0, 32'h0,         32'h0);
    add(1, 1, 0, 32'h0,           1, 0, 0, 2'b01, 0, 32'h0,         32'h0);
    add(1, 1, 1, 32'h0000_00C3,   1, 1, 0, 2'b01, 0, 32'h0000_00C3, 32'h0);
    add(0, 0, 0, 32'h0,           0, 0, 0, 2'b00, 0, 32'h0,         32'h0);

    // reset values
    repeat (3) @(negedge sys_clk);
    #2;
    chk("rst sram_valid", 32'(sram_mem_valid), 32'h0);
    chk("rst cpu_ready",  32'(cpu_mem_ready),  32'h0);
    chk("rst dma_ready",  32'(dma_mem_ready),  32'h0);
    chk("rst timeout",    32'(timeout_err),    32'h0);
    chk("rst owner",      32'(grant_owner),    32'h0);
    @(negedge sys_clk);
    rst_n = 1'b1;

    // table: inputs at negedge, outputs sampled 2 time units later
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge sys_clk);
      cpu_mem_valid  = vecs[i].cpu_v;
      dma_mem_valid  = vecs[i].dma_v;
      sram_mem_ready = vecs[i].rdy;
      sram_mem_rdata = vecs[i].rdata;
      #2;
      chk($sformatf("v%0d sram_valid", i), 32'(sram_mem_valid), 32'(vecs[i].e_sv));
      chk($sformatf("v%0d cpu_ready", i),  32'(cpu_mem_ready),  32'(vecs[i].e_cr));
      chk($sformatf("v%0d dma_ready", i),  32'(dma_mem_ready),  32'(vecs[i].e_dr));
      chk($sformatf("v%0d owner", i),      32'(grant_owner),    32'(vecs[i].e_own));
      chk($sformatf("v%0d timeout", i),    32'(timeout_err),    32'h0);
      chk($sformatf("v%0d cpu_rdata", i),  cpu_mem_rdata,       vecs[i].e_crd);
      chk($sformatf("v%0d dma_rdata", i),  dma_mem_rdata,       vecs[i].e_drd);
      chk($sformatf("v%0d sram_addr", i),  sram_mem_addr,  vecs[i].e_dsel ? DMA_ADDR : CPU_ADDR);
      chk($sformatf("v%0d sram_wdata", i), sram_mem_wdata, vecs[i].e_dsel ? DMA_WDATA : CPU_WDATA);
      chk($sformatf("v%0d sram_wstrb", i), 32'(sram_mem_wstrb),
          32'(vecs[i].e_dsel ? DMA_WSTRB : CPU_WSTRB));
    end

    // watchdog expiry: SRAM silent, fires on the 64th grant cycle
    @(negedge sys_clk);
    cpu_mem_valid  = 1'b1;
    dma_mem_valid  = 1'b0;
    sram_mem_ready = 1'b0;
    sram_mem_rdata = '0;
    @(negedge sys_clk);
    early = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      if (k == 40) dma_mem_valid = 1'b1;
      #2;
      if (k < 64) begin
        if (cpu_mem_ready || timeout_err || !sram_mem_valid || grant_owner != 2'b01) early = 1'b1;
        @(negedge sys_clk);
      end
    end
    chk("wd no_early_end",  32'(early),          32'h0);
    chk("wd cpu_ready",     32'(cpu_mem_ready),  32'h1);
    chk("wd cpu_rdata",     cpu_mem_rdata,       32'hDEAD_BEEF);
    chk("wd timeout_err",   32'(timeout_err),    32'h1);
    chk("wd sram_valid",    32'(sram_mem_valid), 32'h0);
    chk("wd dma_ready",     32'(dma_mem_ready),  32'h0);
    @(negedge sys_clk);
    cpu_mem_valid = 1'b0;
    #2;
    chk("wd idle owner",    32'(grant_owner),    32'h0);
    chk("wd pulse_once",    32'(timeout_err),    32'h0);
    @(negedge sys_clk);
    #2;
    chk("wd next dma owner", 32'(grant_owner),   32'h2);
    chk("wd next dma addr",  sram_mem_addr,      DMA_ADDR);
    sram_mem_ready = 1'b1;
    sram_mem_rdata = 32'h0000_0077;
    #1;
    chk("wd next dma ready", 32'(dma_mem_ready), 32'h1);
    chk("wd next dma rdata", dma_mem_rdata,      32'h0000_0077);
    @(negedge sys_clk);
    dma_mem_valid  = 1'b0;
    sram_mem_ready = 1'b0;
    sram_mem_rdata = '0;

    // boundary: SRAM ready on the 64th grant cycle wins over the timeout
    @(negedge sys_clk);
    cpu_mem_valid = 1'b1;
    @(negedge sys_clk);
    early = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      if (k == 64) begin
        sram_mem_ready = 1'b1;
        sram_mem_rdata = 32'hCAFE_0064;
      end
      #2;
      if (k < 64) begin
        if (cpu_mem_ready || timeout_err) early = 1'b1;
        @(negedge sys_clk);
      end
    end
    chk("bnd no_early_end", 32'(early),          32'h0);
    chk("bnd cpu_ready",    32'(cpu_mem_ready),  32'h1);
    chk("bnd cpu_rdata",    cpu_mem_rdata,       32'hCAFE_0064);
    chk("bnd timeout_err",  32'(timeout_err),    32'h0);
    chk("bnd sram_valid",   32'(sram_mem_valid), 32'h1);
    @(negedge sys_clk);
    cpu_mem_valid  = 1'b0;
    sram_mem_ready = 1'b0;
    sram_mem_rdata = '0;
    #2;
    chk("bnd idle owner",   32'(grant_owner),    32'h0);

    // reset while DMA holds the grant; afterwards CPU wins the tie
    @(negedge sys_clk);
    dma_mem_valid = 1'b1;
    @(negedge sys_clk);
    #2;
    chk("rstmid pre owner",  32'(grant_owner),    32'h2);
    chk("rstmid pre valid",  32'(sram_mem_valid), 32'h1);
    #1;
    rst_n         = 1'b0;
    cpu_mem_valid = 1'b1;
    #1;
    chk("rstmid sram_valid", 32'(sram_mem_valid), 32'h0);
    chk("rstmid dma_ready",  32'(dma_mem_ready),  32'h0);
    chk("rstmid owner",      32'(grant_owner),    32'h0);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    #2;
    chk("rstmid idle owner", 32'(grant_owner),    32'h0);
    @(negedge sys_clk);
    #2;
    chk("rstmid tie owner",  32'(grant_owner),    32'h1);
    chk("rstmid tie addr",   sram_mem_addr,       CPU_ADDR);
    sram_mem_ready = 1'b1;
    sram_mem_rdata = 32'h0000_0099;
    #1;
    chk("rstmid cpu_ready",  32'(cpu_mem_ready),  32'h1);
    chk("rstmid dma_masked", 32'(dma_mem_ready),  32'h0);
    @(negedge sys_clk);
    cpu_mem_valid  = 1'b0;
    dma_mem_valid  = 1'b0;
    sram_mem_ready = 1'b0;
    repeat (2) @(negedge sys_clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
